// File: rtl/tile_map_renderer_if.sv
// Control, tile-memory and pixel-stream signals of the tile-map renderer.
// The renderer takes the master side; the map memory and display path take the slave side.
interface tile_map_renderer_if #(
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned X_BITS    = 8,
  parameter int unsigned Y_BITS    = 7,
  parameter int unsigned CBIT      = 11
);
  logic                 start;
  logic                 hold;
  logic [CBIT:0]        wall_color;
  logic [CBIT:0]        floor_color;
  logic [ADDR_BITS-1:0] map_addr;
  logic                 map_q;
  logic [X_BITS-1:0]    vga_x;
  logic [Y_BITS-1:0]    vga_y;
  logic [CBIT:0]        vga_color;
  logic                 plot;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, hold, wall_color, floor_color, map_q,
    output map_addr, vga_x, vga_y, vga_color, plot, busy, done
  );

  modport slave (
    output start, hold, wall_color, floor_color, map_q,
    input  map_addr, vga_x, vga_y, vga_color, plot, busy, done
  );
endinterface

// File: rtl/tile_map_renderer.sv
// Tile-map rasteriser: scans a MAP_W x MAP_H tile map one tile at a time and streams
// TILE x TILE pixel squares, aligning coordinates with the map memory read latency.
module tile_map_renderer #(
  parameter int unsigned TILE      = 4,
  parameter int unsigned MAP_W     = 29,
  parameter int unsigned MAP_H     = 13,
  parameter int unsigned ADDR_BITS = 11,
  parameter int unsigned X_BITS    = 8,
  parameter int unsigned Y_BITS    = 7,
  parameter int unsigned CBIT      = 11,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned ORIGIN_X  = 0,
  parameter int unsigned ORIGIN_Y  = 0
) (
  input  logic                clock,
  input  logic                reset,
  tile_map_renderer_if.master bus
);
  localparam int unsigned TSH = $clog2(TILE);
  localparam int unsigned DW  = (TILE  > 1) ? $clog2(TILE)  : 1;
  localparam int unsigned TXW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
  localparam int unsigned TYW = (MAP_H > 1) ? $clog2(MAP_H) : 1;
  localparam int unsigned CW  = CBIT + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

  state_t               state_q, state_d;
  logic [DW-1:0]        dx_q, dx_d, dy_q, dy_d;
  logic [TXW-1:0]       tx_q, tx_d;
  logic [TYW-1:0]       ty_q, ty_d;
  logic [ADDR_BITS-1:0] row_q, row_d;
  logic [ADDR_BITS-1:0] map_addr_q, map_addr_d;
  logic [X_BITS-1:0]    px_q [0:RD_LAT];
  logic [X_BITS-1:0]    px_d [0:RD_LAT];
  logic [Y_BITS-1:0]    py_q [0:RD_LAT];
  logic [Y_BITS-1:0]    py_d [0:RD_LAT];
  logic [RD_LAT:0]      pv_q, pv_d;
  logic [X_BITS-1:0]    vga_x_q, vga_x_d;
  logic [Y_BITS-1:0]    vga_y_q, vga_y_d;
  logic [CW-1:0]        vga_color_q, vga_color_d;
  logic                 plot_q, plot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 issue_c, last_pix_c, drained_c;

  always_comb begin
    state_d     = state_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    row_d       = row_q;
    map_addr_d  = map_addr_q;
    px_d        = px_q;
    py_d        = py_q;
    pv_d        = pv_q;
    vga_x_d     = vga_x_q;
    vga_y_d     = vga_y_q;
    vga_color_d = vga_color_q;
    plot_d      = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_c     = 1'b0;

    last_pix_c = (dx_q == DW'(TILE - 1)) && (dy_q == DW'(TILE - 1)) &&
                 (tx_q == TXW'(MAP_W - 1)) && (ty_q == TYW'(MAP_H - 1));
    // Frame is drained once no valid pixel sits in the pipe or the output stage.
    drained_c  = (pv_q == '0) && !plot_q;

    if (!bus.hold) begin
      case (state_q)
        IDLE: if (bus.start) begin
          issue_c = 1'b1;
          busy_d  = 1'b1;
          state_d = last_pix_c ? DRAIN : SCAN;
        end
        SCAN: begin
          issue_c = 1'b1;
          if (last_pix_c) state_d = DRAIN;
        end
        DRAIN: if (drained_c) state_d = FIN;
        FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      pv_d[0] = issue_c;
      if (issue_c) begin
        map_addr_d = ADDR_BITS'(32'(row_q) + 32'(tx_q));
        px_d[0]    = X_BITS'(ORIGIN_X + (32'(tx_q) << TSH) + 32'(dx_q));
        py_d[0]    = Y_BITS'(ORIGIN_Y + (32'(ty_q) << TSH) + 32'(dy_q));
        // dx fastest, then dy, tx, ty; row_q tracks ty*MAP_W without a multiplier.
        if (dx_q == DW'(TILE - 1)) begin
          dx_d = '0;
          if (dy_q == DW'(TILE - 1)) begin
            dy_d = '0;
            if (tx_q == TXW'(MAP_W - 1)) begin
              tx_d = '0;
              if (ty_q == TYW'(MAP_H - 1)) begin
                ty_d  = '0;
                row_d = '0;
              end else begin
                ty_d  = ty_q + TYW'(1);
                row_d = ADDR_BITS'(32'(row_q) + MAP_W);
              end
            end else begin
              tx_d = tx_q + TXW'(1);
            end
          end else begin
            dy_d = dy_q + DW'(1);
          end
        end else begin
          dx_d = dx_q + DW'(1);
        end
      end

      for (int unsigned i = 1; i <= RD_LAT; i++) begin
        px_d[i] = px_q[i-1];
        py_d[i] = py_q[i-1];
        pv_d[i] = pv_q[i-1];
      end

      // Output stage meets map_q exactly RD_LAT cycles after its address.
      if (pv_q[RD_LAT]) begin
        vga_x_d     = px_q[RD_LAT];
        vga_y_d     = py_q[RD_LAT];
        vga_color_d = bus.map_q ? bus.wall_color : bus.floor_color;
        plot_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dx_q        <= '0;
      dy_q        <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      row_q       <= '0;
      map_addr_q  <= '0;
      for (int unsigned i = 0; i <= RD_LAT; i++) begin
        px_q[i] <= '0;
        py_q[i] <= '0;
      end
      pv_q        <= '0;
      vga_x_q     <= '0;
      vga_y_q     <= '0;
      vga_color_q <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      row_q       <= row_d;
      map_addr_q  <= map_addr_d;
      px_q        <= px_d;
      py_q        <= py_d;
      pv_q        <= pv_d;
      vga_x_q     <= vga_x_d;
      vga_y_q     <= vga_y_d;
      vga_color_q <= vga_color_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.map_addr  = map_addr_q;
  assign bus.vga_x     = vga_x_q;
  assign bus.vga_y     = vga_y_q;
  assign bus.vga_color = vga_color_q;
  assign bus.plot      = plot_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed bench for tile_map_renderer: a default instance (RD_LAT=1, origin 0,0) and an
// offset instance (RD_LAT=3, origin 10,5), each fed by a hold-aware synchronous map ROM.
module tb_tile_map_renderer;
  localparam int T  = 4;
  localparam int MW = 29;
  localparam int MH = 13;
  localparam int N  = MW * MH * T * T;
  localparam int BUDGET = 7000;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] wall_c, floor_c;
  logic        mem [0:2047];
  logic        q_a;
  logic        q_b1, q_b2, q_b3;

  int n_checks = 0;
  int n_errors = 0;

  int r_plots, r_first_k, r_busy, r_done, r_done_k, r_bad, r_held_err, r_wall, r_noise;
  int r_first_x, r_first_y, r_last_x, r_last_y, r_busy_after, r_fin;
  int r_xs [17];
  int r_ys [17];
  int r_cs [17];

  tile_map_renderer_if ifa ();
  tile_map_renderer_if ifb ();

  tile_map_renderer u_a (.clock(clock), .reset(reset), .bus(ifa));

  tile_map_renderer #(.RD_LAT(3), .ORIGIN_X(10), .ORIGIN_Y(5))
    u_b (.clock(clock), .reset(reset), .bus(ifb));

  always #5 clock = ~clock;

  assign ifa.wall_color  = wall_c;
  assign ifa.floor_color = floor_c;
  assign ifb.wall_color  = wall_c;
  assign ifb.floor_color = floor_c;
  assign ifa.map_q       = q_a;
  assign ifb.map_q       = q_b3;

  // Synchronous map ROMs that freeze along with the renderer's frozen address.
  always @(posedge clock) if (!ifa.hold) q_a <= mem[ifa.map_addr];
  always @(posedge clock) begin
    if (!ifb.hold) begin
      q_b1 <= mem[ifb.map_addr];
      q_b2 <= q_b1;
      q_b3 <= q_b2;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model_px(input bit sel, input int idx,
                                   output int ex, output int ey, output int ec);
    int dx, dy, tx, ty;
    dx = idx % T;
    dy = (idx / T) % T;
    tx = (idx / (T * T)) % MW;
    ty = idx / (T * T * MW);
    ex = ((sel ? 10 : 0) + tx * T + dx) & 255;
    ey = ((sel ? 5 : 0) + ty * T + dy) & 127;
    ec = mem[ty * MW + tx] ? int'(wall_c) : int'(floor_c);
  endfunction

  function automatic bit in_hold(input int k);
    return k == 10 || k == 11 || k == 12 || k == 1500 || k == 3333 || k == 5000 || k == 6000;
  endfunction

  task automatic set_in(input bit sel, input bit st, input bit hd);
    if (sel) begin
      ifb.start = st;
      ifb.hold  = hd;
    end else begin
      ifa.start = st;
      ifa.hold  = hd;
    end
  endtask

  task automatic idle_gap(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drives one frame from posedge+1 alignment and records what the display path saw.
  task automatic run_frame(input bit sel, input int start_len, input int repulse_at,
                           input int reset_at, input bit use_hold);
    logic p, b, d, held, st, hd;
    int   x, y, c, ex, ey, ec;
    r_plots = 0; r_first_k = -1; r_busy = 0; r_done = 0; r_done_k = -1; r_bad = 0;
    r_held_err = 0; r_wall = 0; r_noise = 0; r_busy_after = -1; r_fin = 0;
    r_first_x = -1; r_first_y = -1; r_last_x = -1; r_last_y = -1;
    held = 1'b0;
    set_in(sel, start_len > 0, 1'b0);
    for (int k = 0; k < BUDGET; k++) begin
      @(posedge clock);
      #1;
      p = sel ? ifb.plot : ifa.plot;
      b = sel ? ifb.busy : ifa.busy;
      d = sel ? ifb.done : ifa.done;
      x = sel ? int'(ifb.vga_x) : int'(ifa.vga_x);
      y = sel ? int'(ifb.vga_y) : int'(ifa.vga_y);
      c = sel ? int'(ifb.vga_color) : int'(ifa.vga_color);
      if (r_done > 0 && k == r_done_k + 1) begin
        r_busy_after = int'(b);
        if (d) r_done++;
        r_fin = 1;
        break;
      end
      if (b) r_busy++;
      if (d) begin
        r_done++;
        r_done_k = k;
      end
      if (held && p) r_held_err++;
      if (p) begin
        model_px(sel, r_plots, ex, ey, ec);
        if (x != ex || y != ey || c != ec) r_bad++;
        if (r_plots == 0) begin
          r_first_k = k;
          r_first_x = x;
          r_first_y = y;
        end
        if (r_plots < 17) begin
          r_xs[r_plots] = x;
          r_ys[r_plots] = y;
          r_cs[r_plots] = c;
        end
        if (c == int'(wall_c)) r_wall++;
        r_last_x = x;
        r_last_y = y;
        r_plots++;
      end
      if (reset_at >= 0 && p && r_plots == reset_at) begin
        reset = 1'b1;
        set_in(sel, 1'b0, 1'b0);
        #1;
        check_eq("rst_plot", ifa.plot, 0);
        check_eq("rst_busy", ifa.busy, 0);
        check_eq("rst_done", ifa.done, 0);
        check_eq("rst_x", ifa.vga_x, 0);
        check_eq("rst_y", ifa.vga_y, 0);
        check_eq("rst_color", ifa.vga_color, 0);
        check_eq("rst_addr", ifa.map_addr, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 20; j++) begin
          @(posedge clock);
          #1;
          if (ifa.plot || ifa.done || ifa.busy) r_noise++;
        end
        r_fin = 1;
        break;
      end
      st = (k + 1 < start_len) || (k + 1 == repulse_at);
      hd = use_hold && in_hold(k);
      set_in(sel, st, hd);
      held = hd;
    end
    set_in(sel, 1'b0, 1'b0);
    check_eq("frame_end", r_fin, 1);
  endtask

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0);
    wall_c  = 12'hFFF;
    floor_c = 12'h000;
    for (int i = 0; i < 2048; i++) mem[i] = 1'b1;

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check_eq("init_plot", ifa.plot, 0);
    check_eq("init_busy", ifa.busy, 0);
    check_eq("init_done", ifa.done, 0);
    check_eq("init_addr", ifa.map_addr, 0);
    check_eq("init_xy", {ifa.vga_x, ifa.vga_y}, 0);
    reset = 1'b0;
    idle_gap(2);
    check_eq("idle_busy", ifa.busy, 0);

    // 1: all-wall map, single start
    run_frame(1'b0, 1, -1, -1, 1'b0);
    check_eq("t1_plots", r_plots, N);
    check_eq("t1_first_k", r_first_k, 2);
    check_eq("t1_busy", r_busy, N + 4);
    check_eq("t1_done_cnt", r_done, 1);
    check_eq("t1_done_k", r_done_k, N + 4);
    check_eq("t1_bad", r_bad, 0);
    check_eq("t1_wall", r_wall, N);
    check_eq("t1_last_x", r_last_x, 115);
    check_eq("t1_last_y", r_last_y, 51);
    check_eq("t1_busy_after", r_busy_after, 0);
    idle_gap(3);

    // 2: only tile (1,0) is wall
    for (int i = 0; i < 2048; i++) mem[i] = 1'b0;
    mem[1] = 1'b1;
    run_frame(1'b0, 1, -1, -1, 1'b0);
    check_eq("t2_plots", r_plots, N);
    check_eq("t2_bad", r_bad, 0);
    check_eq("t2_wall", r_wall, 16);
    check_eq("t2_p0", {r_first_x, r_first_y}, 0);
    check_eq("t2_p1_x", r_xs[1], 1);
    check_eq("t2_p4_xy", {r_xs[4], r_ys[4]}, {32'd0, 32'd1});
    check_eq("t2_p15_xy", {r_xs[15], r_ys[15]}, {32'd3, 32'd3});
    check_eq("t2_p15_c", r_cs[15], 0);
    check_eq("t2_p16_xy", {r_xs[16], r_ys[16]}, {32'd4, 32'd0});
    check_eq("t2_p16_c", r_cs[16], 12'hFFF);
    idle_gap(3);

    // 3: latency 3 with origin offset
    for (int i = 0; i < 2048; i++) mem[i] = (i % 3 == 0);
    wall_c  = 12'hABC;
    floor_c = 12'h123;
    run_frame(1'b1, 1, -1, -1, 1'b0);
    check_eq("t3_plots", r_plots, N);
    check_eq("t3_first_k", r_first_k, 4);
    check_eq("t3_first_x", r_first_x, 10);
    check_eq("t3_first_y", r_first_y, 5);
    check_eq("t3_last_x", r_last_x, 125);
    check_eq("t3_last_y", r_last_y, 56);
    check_eq("t3_bad", r_bad, 0);
    check_eq("t3_c0", r_cs[0], 12'hABC);
    check_eq("t3_done_k", r_done_k, N + 6);
    check_eq("t3_busy", r_busy, N + 6);
    idle_gap(3);

    // 4: seven held cycles mid-frame
    run_frame(1'b0, 1, -1, -1, 1'b1);
    check_eq("t4_plots", r_plots, N);
    check_eq("t4_bad", r_bad, 0);
    check_eq("t4_held_plot", r_held_err, 0);
    check_eq("t4_done_k", r_done_k, N + 11);
    check_eq("t4_busy", r_busy, N + 11);
    check_eq("t4_done_cnt", r_done, 1);
    idle_gap(3);

    // 5: reset at plot 1000, then a clean frame
    run_frame(1'b0, 1, -1, 1000, 1'b0);
    check_eq("t5_abort_plots", r_plots, 1000);
    check_eq("t5_no_done", r_done + r_noise, 0);
    run_frame(1'b0, 1, -1, -1, 1'b0);
    check_eq("t5_first_xy", {r_first_x, r_first_y}, 0);
    check_eq("t5_first_k", r_first_k, 2);
    check_eq("t5_plots", r_plots, N);
    check_eq("t5_bad", r_bad, 0);
    check_eq("t5_done_cnt", r_done, 1);
    idle_gap(3);

    // 6: start held 3 cycles plus a re-pulse while busy
    run_frame(1'b0, 3, 3000, -1, 1'b0);
    check_eq("t6_plots", r_plots, N);
    check_eq("t6_done_cnt", r_done, 1);
    check_eq("t6_done_k", r_done_k, N + 4);
    check_eq("t6_busy_after", r_busy_after, 0);
    idle_gap(3);

    // 6b: start still high after FIN launches a second frame
    run_frame(1'b0, N + 6, -1, -1, 1'b0);
    check_eq("t6b_plots", r_plots, N);
    check_eq("t6b_done_cnt", r_done, 1);
    check_eq("t6b_busy_after", r_busy_after, 1);
    run_frame(1'b0, 0, -1, -1, 1'b0);
    check_eq("t6b_second_plots", r_plots, N);
    check_eq("t6b_second_bad", r_bad, 0);
    check_eq("t6b_second_done", r_done, 1);
    check_eq("t6b_second_busy_after", r_busy_after, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tile_map_renderer.md
Name: tile_map_renderer

Overview:
Parametrised tile-map rasteriser that walks a MAP_W x MAP_H tile map stored in an external synchronous ROM/RAM. Each tile is expanded to a TILE x TILE square of pixels and streamed as (x, y, colour, plot) to the VGA adapter path. Adds over the previous maze drawer:
- start/busy/done handshake with single-frame runs
- a hold (stall) input
- configurable memory read latency with coordinate/colour alignment
- screen origin offset and run-time wall/floor colours

Parameters:
TILE, 4, tile edge in pixels; power of 2, 1..16
MAP_W, 29, tiles per row, 1..64
MAP_H, 13, tile rows, 1..64
ADDR_BITS, 11, width of map_addr; must satisfy 2^ADDR_BITS >= MAP_W*MAP_H
X_BITS, 8, width of vga_x
Y_BITS, 7, width of vga_y
CBIT, 11, colour MSB index (colour width CBIT+1)
RD_LAT, 1, cycles from map_addr to valid map_q, 1..3
ORIGIN_X, 0, pixel x of the tile map's top-left corner
ORIGIN_Y, 0, pixel y of the tile map's top-left corner

Ports:
clock  in  1  system clock (CLOCK_50 domain)
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse requesting a full-map draw
hold  in  1  stall; freezes scan and pipeline while high
wall_color  in  CBIT+1  colour for tiles with map_q=1
floor_color  in  CBIT+1  colour for tiles with map_q=0
map_addr  out  ADDR_BITS  tile address = ty*MAP_W + tx (registered)
map_q  in  1  tile bit returned RD_LAT cycles after map_addr
vga_x  out  X_BITS  pixel x
vga_y  out  Y_BITS  pixel y
vga_color  out  CBIT+1  pixel colour
plot  out  1  pixel valid / write strobe
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse after the last pixel is plotted

Behaviour:
- Reset is asynchronous and active-high. While reset is high, all outputs are 0, all counters are 0 and the FSM is in IDLE. Asserting reset mid-frame aborts the frame immediately. No done pulse is issued for an aborted frame.
- FSM states: IDLE, SCAN, DRAIN, FIN.
  - IDLE -> SCAN when start=1; this is the acceptance cycle. busy rises on the next edge.
  - SCAN issues one address per non-held cycle.
  - SCAN -> DRAIN after the last pixel (dx=dy=TILE-1, tx=MAP_W-1, ty=MAP_H-1) is issued.
  - DRAIN waits until the RD_LAT pipeline has emptied.
  - DRAIN -> FIN; FIN pulses done=1 for exactly one cycle, clears busy, and returns to IDLE.
- start in any state other than IDLE is ignored, with no queueing.
- Scan order: dx fastest, then dy, then tx, then ty. This is the tile-at-a-time order used by the existing maze drawer. Counters wrap to 0 at TILE-1, MAP_W-1 and MAP_H-1 respectively.
- Issue stage, per issued pixel:
  - registers map_addr = ty*MAP_W + tx
  - registers px = ORIGIN_X + tx*TILE + dx, truncated to X_BITS
  - registers py = ORIGIN_Y + ty*TILE + dy, truncated to Y_BITS
  - uses a shift, not a multiplier, for tx*TILE and ty*TILE
- Alignment pipeline:
  - px, py and a valid bit travel through RD_LAT register stages.
  - At the output, vga_x/vga_y are the delayed px/py, and vga_color = map_q ? wall_color : floor_color (sampled at the same edge), registered.
  - plot is the delayed valid bit.
  - Latency from the start acceptance edge to the first plot=1 is RD_LAT+1 cycles.
- hold=1 freezes, for that cycle:
  - scan counters, map_addr and the pipeline stages
  - the FSM (the FIN done pulse is postponed while hold=1)
  - plot, which is forced to 0; vga_x/vga_y/vga_color keep their values
- The memory must hold its map_q while hold=1, because the external RAM's address is frozen.
- The pixel count per frame is exactly MAP_W*MAP_H*TILE*TILE plots. Every (x,y) in the map area is plotted exactly once, and no pixel outside it is plotted.
- Colour inputs are sampled at the output stage, so a change mid-frame affects subsequent pixels only.
- Outside SCAN/DRAIN, plot stays 0. vga_x, vga_y and vga_color keep their last values.

Test Plan:
1. Defaults, map all 1s, wall=12'hFFF, floor=0, single start -> exactly 6032 plot cycles (29*13*16); first plot is 2 cycles after start; done is one pulse; busy high for 6036 cycles.
2. TILE=4, map bit (tx=1,ty=0)=1, rest 0 -> pixels x=4..7, y=0..3 carry 12'hFFF; all other plotted pixels are 0; first 16 plots are x=0..3, y=0..3, dx fastest.
3. RD_LAT=3, ORIGIN_X=10, ORIGIN_Y=5 -> first plot is 4 cycles after start at (10,5); last plot is at (125,56); the colour of each pixel matches its tile bit.
4. hold high for 7 cycles at random points mid-frame -> plot=0 during hold; no pixel is lost or duplicated; total plots still 6032; done is delayed by exactly 7 cycles.
5. Reset asserted at plot #1000, released, then start -> outputs are 0 immediately on reset and no done is seen; the new frame restarts at (ORIGIN_X, ORIGIN_Y) with a full 6032 plots.
6. start re-pulsed while busy, and start held high for 3 cycles -> only one frame is drawn per IDLE acceptance; a held start that is still high in IDLE after FIN starts a second frame.
